// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  localparam int CLK_HZ           = 24_000_000;
  localparam int DEF_MAX_PKT_LEN  = 16;
  localparam int DEF_IDLE_TIMEOUT = CLK_HZ / 100;  // 10 ms of silence mid-packet

  // Ceiling log2, never below 1 so it can size a counter or index directly.
  function automatic int clog2(input int value);
    int result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit searching upward from i_last_owner+1, with wrap.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = clog2(N)
) (
  input  logic [N-1:0]     i_valid,
  input  logic [PTR_W-1:0] i_last_owner,
  output logic [N-1:0]     o_choice,
  output logic             o_found
);

  int               w_pos;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_choice = '0;
    o_found  = 1'b0;
    w_pos    = 0;
    w_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = (int'(i_last_owner) + k) % N;
      w_idx = PTR_W'(w_pos);
      if (!o_found && i_valid[w_idx]) begin
        o_found         = 1'b1;
        o_choice[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX serializer between NUM_REQ byte streams.
//   state   | meaning
//   ST_IDLE | no owner; picks the next requester, grant appears next cycle
//   ST_OWN  | owner streams bytes until last, length limit or idle timeout
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int MAX_PKT_LEN  = DEF_MAX_PKT_LEN,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_tx_valid,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_force_rel,
  output logic [7:0]                o_timeout_cnt
);

  localparam int PTR_W  = clog2(NUM_REQ);
  localparam int LEN_W  = clog2(MAX_PKT_LEN + 1);
  localparam int IDLE_W = clog2(IDLE_TIMEOUT);
  localparam logic [LEN_W-1:0]  LEN_LAST  = LEN_W'(MAX_PKT_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    r_last_owner;
  logic [LEN_W-1:0]    r_len_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic                r_tx_valid;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_force_rel;
  logic [7:0]          r_timeout_cnt;

  logic [NUM_REQ-1:0]  w_choice;
  logic                w_found;
  logic [PTR_W-1:0]    w_pick_idx;
  logic                w_own_valid;
  logic                w_own_last;
  logic [DATA_W-1:0]   w_own_data;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_rel_last;
  logic                w_rel_len;
  logic                w_rel_tmo;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_valid      (i_req_valid),
    .i_last_owner (r_last_owner),
    .o_choice     (w_choice),
    .o_found      (w_found)
  );

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    w_pick_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PTR_W'(i)) begin
        w_own_valid = i_req_valid[i];
        w_own_last  = i_req_last[i];
        w_own_data  = i_req_data[i*DATA_W +: DATA_W];
      end
      if (w_choice[i]) w_pick_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_free = !r_tx_valid || i_tx_ready;
    w_accept    = 1'b0;
    w_rel_last  = 1'b0;
    w_rel_len   = 1'b0;
    w_rel_tmo   = 1'b0;
    o_req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_OWN;
      end
      ST_OWN: begin
        if (w_slot_free) o_req_ready = r_grant;
        w_accept = w_slot_free && w_own_valid;
        // last wins over the length limit, so a full-length packet ending on time is a normal release
        if (w_accept) begin
          w_rel_last = w_own_last;
          w_rel_len  = !w_own_last && (r_len_cnt == LEN_LAST);
        end else begin
          w_rel_tmo  = (r_idle_cnt == IDLE_LAST);
        end
        if (w_rel_last || w_rel_len || w_rel_tmo) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_grant       <= '0;
      r_owner       <= '0;
      r_last_owner  <= PTR_W'(NUM_REQ - 1);
      r_len_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_force_rel   <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      r_force_rel <= w_rel_len || w_rel_tmo;
      if (w_accept) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_own_data;
      end else if (i_tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      if (r_state == ST_IDLE) begin
        r_len_cnt  <= '0;
        r_idle_cnt <= '0;
        if (w_found) begin
          r_grant <= w_choice;
          r_owner <= w_pick_idx;
        end
      end else begin
        if (w_accept) begin
          r_len_cnt  <= r_len_cnt + 1'b1;
          r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_LAST) begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
        if (w_state_nxt == ST_IDLE) begin
          r_grant      <= '0;
          r_last_owner <= r_owner;
        end
        if (w_rel_tmo && (r_timeout_cnt != 8'hFF)) r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

  assign o_tx_valid    = r_tx_valid;
  assign o_tx_data     = r_tx_data;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state == ST_OWN);
  assign o_force_rel   = r_force_rel;
  assign o_timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected TX bytes queued by stimulus, popped by a monitor.
module tb_uart_tx_arbiter;

  localparam int NR  = 2;
  localparam int DW  = 8;
  localparam int MPL = 16;
  localparam int ITO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid, req_last, req_ready, grant;
  logic [NR*DW-1:0]  req_data;
  logic              tx_valid, busy, force_rel;
  logic              tx_ready = 1'b1;
  logic [DW-1:0]     tx_data;
  logic [7:0]        timeout_cnt;

  bit                drv_valid [NR];
  bit                drv_last  [NR];
  logic [DW-1:0]     drv_data  [NR];
  int                acc_cnt   [NR];

  logic [DW-1:0]     exp_q [$];
  logic [DW-1:0]     exp_byte;
  int                n_checks = 0;
  int                n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = drv_valid[i];
      req_last[i]           = drv_last[i];
      req_data[i*DW +: DW]  = drv_data[i];
    end
  end

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_W       (DW),
    .MAX_PKT_LEN  (MPL),
    .IDLE_TIMEOUT (ITO)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .i_req_last    (req_last),
    .o_req_ready   (req_ready),
    .o_tx_valid    (tx_valid),
    .o_tx_data     (tx_data),
    .i_tx_ready    (tx_ready),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_force_rel   (force_rel),
    .o_timeout_cnt (timeout_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every TX handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got %0h expected none", tx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, exp_byte});
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
      drv_data[i]  = '0;
      acc_cnt[i]   = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_byte(input int r, input logic [DW-1:0] d, input bit last);
    bit ok = 1'b0;
    drv_valid[r] = 1'b1;
    drv_data[r]  = d;
    drv_last[r]  = last;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    drv_valid[r] = 1'b0;
    drv_last[r]  = 1'b0;
    if (ok) acc_cnt[r]++;
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout req%0d: got no ready expected ready", r);
    end
  endtask

  task automatic send_pkt(input int r, input int n, input logic [DW-1:0] base, input bit mark_last);
    for (int i = 0; i < n; i++) send_byte(r, DW'(int'(base) + i), mark_last && (i == n - 1));
  endtask

  task automatic expect_bytes(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(int'(base) + i));
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: async reset mid-transfer, then grant two cycles after release
    begin : t1
      bit found;
      do_reset();
      tx_ready     = 1'b0;
      drv_valid[0] = 1'b1;
      drv_data[0]  = 8'h11;
      drv_last[0]  = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        if (tx_valid) found = 1'b1;
      end
      check("t1_txv_pre", tx_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t1_rst_txv",   tx_valid, 0);
      check("t1_rst_txd",   tx_data, 0);
      check("t1_rst_grant", grant, 0);
      check("t1_rst_busy",  busy, 0);
      check("t1_rst_frel",  force_rel, 0);
      check("t1_rst_tcnt",  timeout_cnt, 0);
      check("t1_rst_ready", req_ready, 0);
      drv_valid[0] = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      drv_valid[0] = 1'b1;
      drv_data[0]  = 8'h22;
      drv_last[0]  = 1'b1;
      exp_q.push_back(8'h22);
      @(negedge clk);
      check("t1_grant_c1", grant, 2'b00);
      @(negedge clk);
      check("t1_grant_c2", grant, 2'b01);
      check("t1_ready",    req_ready, 2'b01);
      @(posedge clk);
      #1;
      drv_valid[0] = 1'b0;
      drv_last[0]  = 1'b0;
      wait_drain();
    end

    // Test 2: two contending 3-byte packets, round-robin order
    begin : t2
      logic [NR-1:0] g_exp [6];
      g_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      do_reset();
      expect_bytes(8'hA0, 3);
      expect_bytes(8'hB0, 3);
      fork
        send_pkt(0, 3, 8'hA0, 1'b1);
        send_pkt(1, 3, 8'hB0, 1'b1);
        begin
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t2_grant_c%0d", k), grant, g_exp[k]);
            if (k == 4) check("t2_frel", force_rel, 0);
          end
        end
      join
      wait_drain();
    end

    // Test 3: length-limit forced release on a 20-byte stream with no last
    begin : t3
      do_reset();
      expect_bytes(8'h30, 20);
      fork
        send_pkt(1, 20, 8'h30, 1'b0);
        begin
          for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (k == 16) begin
              check("t3_grant_pre", grant, 2'b10);
              check("t3_frel_pre",  force_rel, 0);
            end
            if (k == 17) begin
              check("t3_grant_rel", grant, 2'b00);
              check("t3_frel_rel",  force_rel, 1);
              check("t3_acc_rel",   acc_cnt[1], 16);
            end
            if (k == 18) begin
              check("t3_grant_re", grant, 2'b10);
              check("t3_frel_re",  force_rel, 0);
            end
          end
        end
      join
      wait_drain();
      check("t3_acc_total", acc_cnt[1], 20);
    end

    // Test 4: owner stalls, idle timeout hands over to the other requester
    begin : t4
      do_reset();
      expect_bytes(8'h40, 2);
      exp_q.push_back(8'hB7);
      fork
        send_pkt(0, 2, 8'h40, 1'b0);
        send_pkt(1, 1, 8'hB7, 1'b1);
        begin
          for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 10) begin
              check("t4_grant_pre", grant, 2'b01);
              check("t4_frel_pre",  force_rel, 0);
              check("t4_tcnt_pre",  timeout_cnt, 0);
            end
            if (k == 11) begin
              check("t4_grant_rel", grant, 2'b00);
              check("t4_frel_rel",  force_rel, 1);
              check("t4_tcnt_rel",  timeout_cnt, 1);
            end
            if (k == 12) begin
              check("t4_grant_nxt", grant, 2'b10);
              check("t4_frel_nxt",  force_rel, 0);
            end
          end
        end
      join
      wait_drain();
      check("t4_tcnt_end", timeout_cnt, 1);
    end

    // Test 5: downstream backpressure holds tx_data and blocks accepts
    begin : t5
      do_reset();
      tx_ready = 1'b0;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h5B);
      fork
        send_pkt(0, 2, 8'h5A, 1'b1);
        begin
          for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2) begin
              check($sformatf("t5_txv_c%0d", k),   tx_valid, 1);
              check($sformatf("t5_txd_c%0d", k),   tx_data, 8'h5A);
              check($sformatf("t5_ready_c%0d", k), req_ready, 2'b00);
            end
          end
          @(posedge clk);
          #1 tx_ready = 1'b1;
          @(negedge clk);
          check("t5_ready_resume", req_ready, 2'b01);
          @(negedge clk);
          check("t5_txd_next", tx_data, 8'h5B);
          check("t5_txv_next", tx_valid, 1);
        end
      join
      wait_drain();
    end

    // Test 6: lone requester, back-to-back packets, one idle cycle between grants
    begin : t6
      logic [NR-1:0] g_exp [11];
      logic          v_exp [11];
      g_exp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
      v_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      expect_bytes(8'h60, 6);
      fork
        begin
          send_pkt(0, 2, 8'h60, 1'b1);
          send_pkt(0, 2, 8'h62, 1'b1);
          send_pkt(0, 2, 8'h64, 1'b1);
        end
        begin
          for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check($sformatf("t6_grant_c%0d", k), grant, g_exp[k]);
            check($sformatf("t6_txv_c%0d", k), tx_valid, v_exp[k]);
          end
        end
      join
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-stream requesters, such as the I2C-decoded byte stream and a status/heartbeat message source. Arbitration is round-robin and packet-atomic: once granted, a requester keeps the transmitter until its last byte, a length limit or an idle timeout. The block sits between the byte producers and the UART TX serializer, on the 24 MHz internal-oscillator clock domain.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width
MAX_PKT_LEN, 16, max bytes per grant before forced release (1..255)
IDLE_TIMEOUT, 240000, cycles without an accepted beat mid-packet before release (10 ms at 24 MHz)

Ports:
clk  in  1  system clock, 24 MHz
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  marks the final byte of a packet
req_ready  out  NUM_REQ  byte accepted when valid && ready
tx_valid  out  1  byte valid to the UART TX
tx_data  out  DATA_W  byte to the UART TX
tx_ready  in  1  UART TX can take the byte
grant  out  NUM_REQ  one-hot current owner; all zero when idle
busy  out  1  a grant is held
force_rel  out  1  one-cycle pulse on length or timeout release
timeout_cnt  out  8  saturating count of timeout releases

Behaviour:
- Reset, asserted low and applied asynchronously:
  - state=IDLE; grant=0, busy=0, tx_valid=0, tx_data=0, force_rel=0, timeout_cnt=0.
  - RR pointer points at requester 0 first.
  - Any byte held in the output register is discarded.
- States: IDLE, OWN.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from (last_owner+1) mod NUM_REQ, with wrap.
  - Registered: the grant appears the next cycle, state→OWN, len_cnt=0, idle_cnt=0.
  - req_ready=0 in IDLE.
- OWN:
  - req_ready[i] = grant[i] && (!tx_valid || tx_ready), combinational; the ready for all other requesters is 0.
  - On accept: tx_data<=req_data[owner] and tx_valid<=1 next cycle, i.e. latency 1 cycle.
  - tx_valid clears on a tx_ready handshake when no new byte is accepted the same cycle.
  - Simultaneous drain and accept gives back-to-back bytes with no bubble.
- Output rules: tx_valid/tx_data hold stable while tx_valid && !tx_ready. tx_valid never drops without a handshake, except on reset.
- len_cnt increments per accepted byte; width clog2(MAX_PKT_LEN+1).
- idle_cnt increments each OWN cycle with no accept, clears on accept, saturates.
- Release, in priority order, all evaluated on the accept cycle:
  1. Accepted byte with req_last=1 → IDLE, no force_rel.
  2. len_cnt reaches MAX_PKT_LEN on the accepted byte → IDLE, force_rel pulse.
  3. idle_cnt==IDLE_TIMEOUT-1 → IDLE, force_rel pulse, timeout_cnt+1 (saturates at 255).
  - If last and the length limit coincide, it is a normal release with no pulse.
- After release, last_owner=owner and grant drops the next cycle.
- Minimum one IDLE cycle between grants; a re-grant takes effect 2 cycles after the releasing accept.
- A byte already in the tx output register is still delivered after release; the next owner's first accept waits on the normal ready rule.
- The arbiter ignores req_valid changes of non-owners. Requesters must hold valid/data until ready.
- The RR pointer advances only on release; a lone requester is re-granted repeatedly.

Decomposition:
- Shared package uart_arb_pkg:
  - state encoding (IDLE, OWN)
  - clog2 helper
  - default MAX_PKT_LEN/IDLE_TIMEOUT constants tied to CLK_HZ=24_000_000
- One sub-module rr_pick, combinational: inputs valid[NUM_REQ], last_owner; outputs a one-hot choice and found. It is reusable by other shared-resource blocks.

Test Plan:
1. Reset low mid-transfer with tx_valid=1 → all outputs 0 immediately, without waiting for clk; after release, req0 valid alone → grant=01 two cycles after reset deasserts.
2. req0 and req1 both valid from IDLE, each with a 3-byte packet (A0 A1 A2 with last, B0 B1 B2 with last), tx_ready=1 → tx order A0 A1 A2, one IDLE cycle, B0 B1 B2; grant 01→00→10.
3. req1 streams 20 bytes, none marked last, MAX_PKT_LEN=16 → 16 bytes sent, then force_rel=1 for one cycle, grant→00, then remaining bytes under a new grant.
4. Owner stalls mid-packet with IDLE_TIMEOUT=8 (bench override) → release 8 cycles after the last accept, force_rel pulse, timeout_cnt=1; the other requester is granted next.
5. tx_ready held 0 for 5 cycles with tx_valid=1, data 0x5A → tx_data stays 0x5A and req_ready=0 throughout; accept resumes on the cycle tx_ready=1.
6. Single requester sending back-to-back packets → re-granted each time with exactly one IDLE cycle between packets; no bubbles within a packet when tx_ready=1.
